// File: rtl/monitoreo_multicanal.sv
// monitoreo_multicanal: N-channel temperature monitor with persistence filter.
// Each channel classifies a signed sample as FRIO / NORMAL / CALOR and only
// raises its alarm after PERSIST consecutive valid out-of-band samples.
// Optional feature macro: MON_HYST_EN (hysteresis on the exit thresholds).
// Input qualifier: muestra_valida=1 marks temp_entrada as a sample for every
// channel on that edge; with muestra_valida=0 nothing advances or clears.
module monitoreo_multicanal #(
    parameter int N_CH    = 4,
    parameter int W       = 11,
    parameter int T_LOW   = 180,
    parameter int T_HIGH  = 259,
    parameter int PERSIST = 6,
    parameter int HYST    = 10
) (
    input  logic                       clk,
    input  logic                       arst_n,
    input  logic [N_CH*W-1:0]          temp_entrada,
    input  logic                       muestra_valida,
    output logic [N_CH-1:0]            alerta,
    output logic [N_CH-1:0]            calefactor,
    output logic [N_CH-1:0]            ventilador,
    output logic [2*N_CH-1:0]          estado_actual,
    output logic                       alerta_global,
    output logic [$clog2(N_CH+1)-1:0]  n_alertas
);

    localparam int CW = $clog2(PERSIST + 1);
    localparam int NW = $clog2(N_CH + 1);

`ifdef MON_HYST_EN
    localparam bit USE_HYST = 1'b1;
`else
    localparam bit USE_HYST = 1'b0;
`endif

    // Thresholds held one bit wider than the sample so T_LOW+HYST and
    // T_HIGH-HYST can never wrap.
    localparam logic [CW-1:0]    P_SAT       = CW'(PERSIST);
    localparam logic signed [W:0] LOW_X       = (W+1)'(T_LOW);
    localparam logic signed [W:0] HIGH_X      = (W+1)'(T_HIGH);
    localparam logic signed [W:0] LOW_EXIT_X  = (W+1)'(T_LOW + (USE_HYST ? HYST : 0));
    localparam logic signed [W:0] HIGH_EXIT_X = (W+1)'(T_HIGH - (USE_HYST ? HYST : 0));

    typedef enum logic [1:0] {
        NORMAL = 2'b00,
        FRIO   = 2'b01,
        CALOR  = 2'b10
    } state_t;

    logic [N_CH-1:0] alerta_d;
    logic [N_CH-1:0] calefactor_d;
    logic [N_CH-1:0] ventilador_d;
    logic [NW-1:0]   n_alertas_d;

    for (genvar g = 0; g < N_CH; g++) begin : g_canal
        logic signed [W-1:0] samp;
        logic signed [W:0]   samp_x;
        logic                es_frio;
        logic                es_calor;
        logic                sale_frio;
        logic                sale_calor;
        state_t              state_q;
        state_t              state_d;
        logic [CW-1:0]       cnt_frio_q;
        logic [CW-1:0]       cnt_frio_d;
        logic [CW-1:0]       cnt_calor_q;
        logic [CW-1:0]       cnt_calor_d;

        assign samp       = temp_entrada[g*W +: W];
        assign samp_x     = {samp[W-1], samp};
        assign es_frio    = (samp_x < LOW_X);
        assign es_calor   = (samp_x > HIGH_X);
        // Without hysteresis these reduce to "not cold" / "not hot".
        assign sale_frio  = (samp_x >= LOW_EXIT_X);
        assign sale_calor = (samp_x <= HIGH_EXIT_X);

        // State and persistence counters; reset drops any partial streak.
        always_ff @(posedge clk) begin
            if (!arst_n) begin
                state_q     <= NORMAL;
                cnt_frio_q  <= '0;
                cnt_calor_q <= '0;
            end else begin
                state_q     <= state_d;
                cnt_frio_q  <= cnt_frio_d;
                cnt_calor_q <= cnt_calor_d;
            end
        end

        // Counter update, then next state from the updated counters.
        always_comb begin
            state_d     = state_q;
            cnt_frio_d  = cnt_frio_q;
            cnt_calor_d = cnt_calor_q;
            if (muestra_valida) begin
                if (es_frio) begin
                    cnt_frio_d  = (cnt_frio_q == P_SAT) ? cnt_frio_q : cnt_frio_q + 1'b1;
                    cnt_calor_d = '0;
                end else if (es_calor) begin
                    cnt_calor_d = (cnt_calor_q == P_SAT) ? cnt_calor_q : cnt_calor_q + 1'b1;
                    cnt_frio_d  = '0;
                end else begin
                    cnt_frio_d  = '0;
                    cnt_calor_d = '0;
                end
                // An opposite-extreme sample is also an exit sample, so
                // FRIO<->CALOR always passes through NORMAL.
                case (state_q)
                    NORMAL: begin
                        if (cnt_frio_d == P_SAT)       state_d = FRIO;
                        else if (cnt_calor_d == P_SAT) state_d = CALOR;
                    end
                    FRIO:    if (sale_frio)  state_d = NORMAL;
                    CALOR:   if (sale_calor) state_d = NORMAL;
                    default: state_d = NORMAL;
                endcase
            end
        end

        assign alerta_d[g]     = (state_d != NORMAL);
        assign calefactor_d[g] = (state_d == FRIO);
        assign ventilador_d[g] = (state_d == CALOR);
        assign estado_actual[2*g +: 2] = state_q;
    end

    // Count of channels that will be alarmed after this edge.
    always_comb begin
        n_alertas_d = '0;
        for (int i = 0; i < N_CH; i++) begin
            n_alertas_d = n_alertas_d + NW'(alerta_d[i]);
        end
    end

    // Registered outputs, updated on the same edge as the channel states.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            alerta        <= '0;
            calefactor    <= '0;
            ventilador    <= '0;
            alerta_global <= 1'b0;
            n_alertas     <= '0;
        end else begin
            alerta        <= alerta_d;
            calefactor    <= calefactor_d;
            ventilador    <= ventilador_d;
            alerta_global <= |alerta_d;
            n_alertas     <= n_alertas_d;
        end
    end

endmodule

// File: tb/tb_monitoreo_multicanal.sv
// Directed bench for monitoreo_multicanal (default parameters, 4 channels).
// Expected channel states are written by hand; the other outputs are decoded
// from that expected state vector.
module tb_monitoreo_multicanal;

    localparam int N_CH = 4;
    localparam int W    = 11;

    logic                clk;
    logic                arst_n;
    logic [N_CH*W-1:0]   temp_entrada;
    logic                muestra_valida;
    logic [N_CH-1:0]     alerta;
    logic [N_CH-1:0]     calefactor;
    logic [N_CH-1:0]     ventilador;
    logic [2*N_CH-1:0]   estado_actual;
    logic                alerta_global;
    logic [2:0]          n_alertas;

    int n_checks;
    int n_errors;

    monitoreo_multicanal dut (
        .clk            (clk),
        .arst_n         (arst_n),
        .temp_entrada   (temp_entrada),
        .muestra_valida (muestra_valida),
        .alerta         (alerta),
        .calefactor     (calefactor),
        .ventilador     (ventilador),
        .estado_actual  (estado_actual),
        .alerta_global  (alerta_global),
        .n_alertas      (n_alertas)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of samples, then look at outputs 1ns after the edge.
    task automatic paso(input int t0, input int t1, input int t2, input int t3, input logic v);
        temp_entrada   = {W'(t3), W'(t2), W'(t1), W'(t0)};
        muestra_valida = v;
        @(posedge clk);
        #1;
    endtask

    task automatic repite(input int t0, input int t1, input int t2, input int t3,
                          input logic v, input int n);
        for (int k = 0; k < n; k++) paso(t0, t1, t2, t3, v);
    endtask

    // Compare every output against what the expected state vector implies.
    task automatic check_all(input string tag, input logic [7:0] exp_est);
        logic [3:0] e_cal;
        logic [3:0] e_ven;
        logic [3:0] e_ale;
        int         e_n;
        e_n = 0;
        for (int i = 0; i < N_CH; i++) begin
            e_cal[i] = (exp_est[2*i +: 2] == 2'b01);
            e_ven[i] = (exp_est[2*i +: 2] == 2'b10);
            e_ale[i] = (exp_est[2*i +: 2] != 2'b00);
            if (e_ale[i]) e_n++;
        end
        check_eq({tag, ".estado"},     32'(estado_actual), 32'(exp_est));
        check_eq({tag, ".alerta"},     32'(alerta),        32'(e_ale));
        check_eq({tag, ".calefactor"}, 32'(calefactor),    32'(e_cal));
        check_eq({tag, ".ventilador"}, 32'(ventilador),    32'(e_ven));
        check_eq({tag, ".global"},     32'(alerta_global), 32'(e_ale != 4'b0));
        check_eq({tag, ".n_alertas"},  32'(n_alertas),     32'(e_n));
    endtask

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        arst_n         = 1'b0;
        temp_entrada   = '0;
        muestra_valida = 1'b0;

        // 1. Reset with a cold valid sample on ch0 still gives all zeros
        repite(100, 200, 200, 200, 1'b1, 2);
        check_all("reset", 8'h00);
        arst_n = 1'b1;

        // 2. Cold persistence on ch0
        repite(150, 200, 200, 200, 1'b1, 5);
        check_all("frio_5", 8'h00);
        paso(150, 200, 200, 200, 1'b1);
        check_all("frio_6", 8'h01);
        paso(200, 200, 200, 200, 1'b1);
        check_all("frio_exit", 8'h00);
        repite(150, 200, 200, 200, 1'b1, 5);
        paso(200, 200, 200, 200, 1'b1);
        check_all("frio_5_break", 8'h00);
        paso(150, 200, 200, 200, 1'b1);
        check_all("frio_restart", 8'h00);
        paso(200, 200, 200, 200, 1'b1);

        // 3. Hot on ch2 with invalid gaps (gap data is in-band and ignored)
        repite(200, 200, 300, 200, 1'b1, 3);
        repite(200, 200, 200, 200, 1'b0, 4);
        check_all("gap_hold", 8'h00);
        repite(200, 200, 300, 200, 1'b1, 2);
        check_all("gap_5", 8'h00);
        paso(200, 200, 300, 200, 1'b1);
        check_all("gap_6", 8'h20);
        paso(200, 200, 200, 200, 1'b0);
        check_all("calor_hold_invalid", 8'h20);
        paso(200, 200, 200, 200, 1'b1);
        check_all("calor_exit", 8'h00);

        // Exact thresholds on ch1: 180 and 259 in-band, 179 cold, 260 hot
        repite(200, 180, 200, 200, 1'b1, 6);
        check_all("edge_180", 8'h00);
        repite(200, 259, 200, 200, 1'b1, 6);
        check_all("edge_259", 8'h00);
        repite(200, 179, 200, 200, 1'b1, 6);
        check_all("edge_179", 8'h04);
        paso(200, 200, 200, 200, 1'b1);
        repite(200, 260, 200, 200, 1'b1, 6);
        check_all("edge_260", 8'h08);
        paso(200, 200, 200, 200, 1'b1);
        check_all("edge_clear", 8'h00);

        // 4. Cold -> hot on ch1 goes through NORMAL
        repite(200, 150, 200, 200, 1'b1, 6);
        check_all("c2h_frio", 8'h04);
        paso(200, 300, 200, 200, 1'b1);
        check_all("c2h_normal", 8'h00);
        repite(200, 300, 200, 200, 1'b1, 4);
        check_all("c2h_5", 8'h00);
        paso(200, 300, 200, 200, 1'b1);
        check_all("c2h_calor", 8'h08);
        paso(200, 200, 200, 200, 1'b1);

        // 5. Exit threshold of FRIO on ch0
        repite(150, 200, 200, 200, 1'b1, 6);
        check_all("hyst_frio", 8'h01);
`ifdef MON_HYST_EN
        paso(185, 200, 200, 200, 1'b1);
        check_all("hyst_185", 8'h01);
        paso(190, 200, 200, 200, 1'b1);
        check_all("hyst_190", 8'h00);
`else
        paso(180, 200, 200, 200, 1'b1);
        check_all("plain_180", 8'h00);
`endif

        // Negative sample on ch3 is cold
        repite(200, 200, 200, -5, 1'b1, 6);
        check_all("negativo", 8'h40);
        paso(200, 200, 200, 200, 1'b1);
        check_all("negativo_exit", 8'h00);

        // 6. All channels hot, then a reset in the middle of a second streak
        repite(300, 300, 300, 300, 1'b1, 6);
        check_all("multi_calor", 8'hAA);
        paso(200, 200, 200, 200, 1'b1);
        check_all("multi_exit", 8'h00);
        repite(300, 300, 300, 300, 1'b1, 3);
        arst_n = 1'b0;
        paso(300, 300, 300, 300, 1'b1);
        check_all("multi_reset", 8'h00);
        arst_n = 1'b1;
        repite(300, 300, 300, 300, 1'b1, 5);
        check_all("multi_fresh_5", 8'h00);
        paso(300, 300, 300, 300, 1'b1);
        check_all("multi_fresh_6", 8'hAA);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
